// File: rtl/alu_hs_unit_if.sv
// ---------------------------------------------------------------------------
// alu_hs_unit_if
// Request/response bus for alu_hs_unit: a valid/ready request channel
// carrying {ctrl, x, y} and a valid/ready result channel carrying
// {data, carry}.
//   slave  : the ALU responder (drives in_ready, out_valid/out_data/out_carry)
//   master : the initiator (drives the request and out_ready)
// ---------------------------------------------------------------------------
interface alu_hs_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_ctrl;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;

  modport slave (
    input  in_valid, in_ctrl, in_x, in_y, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );

  modport master (
    output in_valid, in_ctrl, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );
endinterface

// File: rtl/alu_hs_unit.sv
// ---------------------------------------------------------------------------
// alu_hs_unit
// Handshaked multi-cycle responder for the 8-bit ALU op set. One request is
// accepted in IDLE, evaluated in EXEC (variable shifts advance one bit per
// cycle), and the registered result is held in DONE until consumed.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_hs_unit_if.slave (request and result channels)
//   busy   : high while an op is in EXEC or DONE
// ---------------------------------------------------------------------------
module alu_hs_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_hs_unit_if.slave    bus,
  output logic            busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOR = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_EQ  = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;      // operand y; doubles as the shift working value
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;

  logic             accept;
  logic             is_shift;
  logic             step;     // advance the shifter by one bit this cycle
  logic             finish;   // capture the result and enter DONE
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [WIDTH:0]   sum;

  assign is_shift = (ctrl_q == OP_SLL) || (ctrl_q == OP_SRL);
  assign sum      = {1'b0, x_q} + {1'b0, y_q};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    step          = 1'b0;
    finish        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // A zero shift count (or any non-shift op) finishes on the first
        // EXEC cycle; otherwise shift until the count drains.
        if (!is_shift || cnt_q == '0) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (ctrl_q)
      OP_ADD: {res_c, res} = sum;
      OP_SUB: begin
        res   = x_q - y_q;
        res_c = (x_q < y_q);
      end
      OP_AND: res = x_q & y_q;
      OP_OR:  res = x_q | y_q;
      OP_NOT: res = ~x_q;
      OP_XOR: res = x_q ^ y_q;
      OP_NOR: res = ~(x_q | y_q);
      OP_SLL,
      OP_SRL: res = y_q;
      OP_SRA: res = {x_q[WIDTH-1], x_q[WIDTH-1:1]};
      OP_ROL: res = {x_q[WIDTH-2:0], x_q[WIDTH-1]};
      OP_ROR: res = {x_q[0], x_q[WIDTH-1:1]};
      OP_EQ:  res = (x_q == y_q) ? WIDTH'(1) : '0;
      default: res = '0;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every datapath register is reset, so an op cut short by reset
  // leaves no stale operands or result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        ctrl_q <= bus.in_ctrl;
        x_q    <= bus.in_x;
        y_q    <= bus.in_y;
        cnt_q  <= bus.in_x[SHW-1:0];
      end
      if (step) begin
        y_q   <= (ctrl_q == OP_SLL) ? (y_q << 1) : (y_q >> 1);
        cnt_q <= cnt_q - SHW'(1);
      end
      if (finish) begin
        data_q  <= res;
        carry_q <= res_c;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_carry = carry_q;

endmodule
